// File: rtl/mod_n_t_ff_counter_pkg.sv
// Shared constants and helpers for the modulo-N T flip-flop counter.
package mod_n_t_ff_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Ceiling log2, used to confirm MOD fits in WIDTH bits at elaboration.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mod_n_t_ff_counter_t_ff.sv
// Single T flip-flop with asynchronous active-high reset to 0.
module mod_n_t_ff_counter_t_ff (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)    q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/mod_n_t_ff_counter.sv
// Up/down modulo-MOD counter built from T flip-flops, with load, optional
// saturation, cascade terminal count and registered wrap/load-error pulses.
module mod_n_t_ff_counter
  import mod_n_t_ff_counter_pkg::*;
#(
  parameter int unsigned MOD      = 12,
  parameter int unsigned WIDTH    = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MOD < 2 || clog2_f(MOD) > WIDTH) begin : g_bad_params
    $error("mod_n_t_ff_counter: MOD must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] term_val;
  logic             wrap_d;
  logic             load_err_d;

  assign term_val  = (up_dn == DIR_DN) ? '0 : MAX_CNT;
  assign tc        = in_en & ~load & (count_q == term_val);
  assign count_out = count_q;

  // Next-count selection; the flops only see the bits that must flip.
  always_comb begin
    next_count = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        next_count = load_val;
      end else begin
        next_count = '0;
        load_err_d = 1'b1;
      end
    end else if (in_en) begin
      if ({1'b0, count_q} >= MOD_EXT) begin
        next_count = '0;
      end else if (count_q == term_val) begin
        wrap_d = 1'b1;
        if (!SATURATE) next_count = (up_dn == DIR_UP) ? '0 : MAX_CNT;
      end else if (up_dn == DIR_UP) begin
        next_count = count_q + WIDTH'(1);
      end else begin
        next_count = count_q - WIDTH'(1);
      end
    end
    toggle = count_q ^ next_count;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mod_n_t_ff_counter_t_ff u_t_ff (
      .clk (clk),
      .rst (rst),
      .t   (toggle[i]),
      .q   (count_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_d;
      load_err <= load_err_d;
    end
  end

endmodule

// File: tb/tb_mod_n_t_ff_counter.sv
// Self-checking bench: wrapping, saturating and cascaded counters compared
// every cycle against an arithmetic model, plus directed literal checks.
module tb_mod_n_t_ff_counter;

  typedef struct packed {
    int   cnt;
    logic w;
    logic e;
  } mres_t;

  logic       clk;
  logic       rst;
  logic       cas_rst;
  logic       in_en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic       cas_en;

  logic [3:0] a_cnt, s_cnt, c0_cnt, c1_cnt;
  logic       a_tc, a_wrap, a_err;
  logic       s_tc, s_wrap, s_err;
  logic       c0_tc, c0_wrap, c0_err;
  logic       c1_tc, c1_wrap, c1_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mres_t ma, ms;
  int    k;
  bit    cw0, cw1;

  mod_n_t_ff_counter #(.MOD(12), .WIDTH(4), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_en(in_en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count_out(a_cnt), .tc(a_tc), .wrap(a_wrap), .load_err(a_err));

  mod_n_t_ff_counter #(.MOD(10), .WIDTH(4), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst(rst), .in_en(in_en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count_out(s_cnt), .tc(s_tc), .wrap(s_wrap), .load_err(s_err));

  mod_n_t_ff_counter #(.MOD(12), .WIDTH(4), .SATURATE(1'b0)) u_c0 (
    .clk(clk), .rst(cas_rst), .in_en(cas_en), .up_dn(1'b1), .load(1'b0),
    .load_val(4'd0), .count_out(c0_cnt), .tc(c0_tc), .wrap(c0_wrap), .load_err(c0_err));

  mod_n_t_ff_counter #(.MOD(12), .WIDTH(4), .SATURATE(1'b0)) u_c1 (
    .clk(clk), .rst(cas_rst), .in_en(c0_tc), .up_dn(1'b1), .load(1'b0),
    .load_val(4'd0), .count_out(c1_cnt), .tc(c1_tc), .wrap(c1_wrap), .load_err(c1_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One clock edge of a modulo counter, expressed as modular arithmetic.
  function automatic mres_t mstep(input int modv, input bit sat, input int c,
                                  input bit en, input bit up, input bit ld, input int lv);
    mres_t r;
    int    raw;
    r.cnt = c;
    r.w   = 1'b0;
    r.e   = 1'b0;
    if (ld) begin
      if (lv < modv) r.cnt = lv;
      else begin
        r.cnt = 0;
        r.e   = 1'b1;
      end
    end else if (en) begin
      if (c >= modv) r.cnt = 0;
      else begin
        raw   = up ? c + 1 : c - 1;
        r.w   = (raw < 0) || (raw >= modv);
        r.cnt = (sat && r.w) ? c : (raw + modv) % modv;
      end
    end
    return r;
  endfunction

  function automatic int tc_exp(input int modv, input int c, input bit en, input bit up, input bit ld);
    return int'(en && !ld && (c == (up ? modv - 1 : 0)));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '0;
      ms <= '0;
    end else begin
      ma <= mstep(12, 1'b0, ma.cnt, in_en, up_dn, load, int'(load_val));
      ms <= mstep(10, 1'b1, ms.cnt, in_en, up_dn, load, int'(load_val));
    end
  end

  // Cascade model: k is the number of enabled edges; stage digits are base-12.
  always @(posedge clk or posedge cas_rst) begin
    if (cas_rst) begin
      k   <= 0;
      cw0 <= 1'b0;
      cw1 <= 1'b0;
    end else if (cas_en) begin
      k   <= k + 1;
      cw0 <= ((k + 1) % 12 == 0);
      cw1 <= ((k + 1) % 144 == 0);
    end else begin
      cw0 <= 1'b0;
      cw1 <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_cnt",   int'(a_cnt),  ma.cnt);
      chk("a_wrap",  int'(a_wrap), int'(ma.w));
      chk("a_err",   int'(a_err),  int'(ma.e));
      chk("a_tc",    int'(a_tc),   tc_exp(12, ma.cnt, in_en, up_dn, load));
      chk("s_cnt",   int'(s_cnt),  ms.cnt);
      chk("s_wrap",  int'(s_wrap), int'(ms.w));
      chk("s_err",   int'(s_err),  int'(ms.e));
      chk("s_tc",    int'(s_tc),   tc_exp(10, ms.cnt, in_en, up_dn, load));
      chk("c0_cnt",  int'(c0_cnt), k % 12);
      chk("c1_cnt",  int'(c1_cnt), (k / 12) % 12);
      chk("c0_wrap", int'(c0_wrap), int'(cw0));
      chk("c1_wrap", int'(c1_wrap), int'(cw1));
      chk("c0_tc",   int'(c0_tc),  int'(cas_en && (k % 12 == 11)));
      chk("c1_tc",   int'(c1_tc),  int'(cas_en && (k % 144 == 143)));
      chk("c_err",   int'(c0_err | c1_err), 0);
    end
  end

  initial begin
    rst      = 1'b1;
    cas_rst  = 1'b1;
    in_en    = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;
    cas_en   = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_cnt",  int'(a_cnt),  0);
    chk("rst_wrap", int'(a_wrap), 0);
    chk("rst_err",  int'(a_err),  0);
    rst     = 1'b0;
    cas_rst = 1'b0;

    // Up count from reset: 0..11 repeating, wrap on 11->0, tc at 11.
    in_en = 1'b1;
    up_dn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("up_cnt",  int'(a_cnt),  i % 12);
      chk("up_wrap", int'(a_wrap), int'(i % 12 == 0));
      chk("up_tc",   int'(a_tc),   int'(i % 12 == 11));
    end

    // Reset between edges at count 6 clears at once; count resumes at 1.
    rst = 1'b1;
    #1;
    chk("async_rst_cnt",  int'(a_cnt),  0);
    chk("async_rst_wrap", int'(a_wrap), 0);
    rst = 1'b0;
    tick();
    chk("resume_cnt", int'(a_cnt), 1);

    // Down count from reset: 11, 10, ..., 0 with wrap on 0->11.
    rst   = 1'b1;
    up_dn = 1'b0;
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("dn_cnt",  int'(a_cnt),  (12 - i) % 12);
      chk("dn_wrap", int'(a_wrap), int'(i == 1));
    end

    // Loads take priority over counting; out-of-range load clears and flags.
    load     = 1'b1;
    load_val = 4'd7;
    #1;
    chk("tc_load_mask", int'(a_tc), 0);
    tick();
    chk("load7_cnt", int'(a_cnt), 7);
    chk("load7_err", int'(a_err), 0);
    load_val = 4'd13;
    tick();
    chk("load13_cnt", int'(a_cnt), 0);
    chk("load13_err", int'(a_err), 1);
    load  = 1'b0;
    in_en = 1'b0;
    tick();
    chk("hold_cnt", int'(a_cnt), 0);
    chk("hold_err", int'(a_err), 0);

    // Saturating MOD=10 counter holds at 9 and pulses wrap each edge there.
    rst = 1'b1;
    #1;
    rst   = 1'b0;
    in_en = 1'b1;
    up_dn = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("sat_cnt",  int'(s_cnt),  (i < 9) ? i : 9);
      chk("sat_wrap", int'(s_wrap), int'(i >= 10));
      chk("sat_tc",   int'(s_tc),   int'(i >= 9));
    end
    up_dn = 1'b0;
    tick();
    chk("sat_dn_cnt",  int'(s_cnt),  8);
    chk("sat_dn_wrap", int'(s_wrap), 0);

    // Two-stage cascade: stage 1 steps every 12 edges and wraps at 144.
    cas_en = 1'b1;
    for (int i = 1; i <= 144; i++) begin
      tick();
      if (i == 12) chk("cas_c1_first", int'(c1_cnt), 1);
      if (i == 143) begin
        chk("cas_tc0_143", int'(c0_tc),  1);
        chk("cas_c1_143",  int'(c1_cnt), 11);
      end
      if (i == 144) begin
        chk("cas_c0_144",   int'(c0_cnt),  0);
        chk("cas_c1_144",   int'(c1_cnt),  0);
        chk("cas_wrap_144", int'(c1_wrap), 1);
      end
    end

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      in_en    = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1) == 1;
      load     = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      cas_en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      tick();
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
